// File: rtl/keccak_padder_multi.sv
// keccak_padder_multi
// Packs a byte stream of IN_W-bit words into rate-sized Keccak blocks for
// SHA3-256, SHA3-512, SHAKE128 and SHAKE256. Applies the domain-separation
// suffix and pad10*1, then presents each block to the permutation under a
// ready/ack handshake. The hash mode is captured while reset is high.
module keccak_padder_multi #(
  parameter int IN_W = 32,
  parameter int BW   = (IN_W > 8) ? $clog2(IN_W / 8) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [1:0]      mode_i,
  input  logic [IN_W-1:0] in_i,
  input  logic            in_ready_i,
  input  logic            is_last_i,
  input  logic [BW-1:0]   byte_num_i,
  input  logic            f_ack_i,
  output logic            buffer_full_o,
  output logic [1343:0]   out_o,
  output logic            out_ready_o,
  output logic            out_last_o
);

  localparam int OUT_W     = 1344;
  localparam int NB        = IN_W / 8;
  localparam int MAX_WORDS = OUT_W / IN_W;
  localparam int CW        = $clog2(MAX_WORDS);

  // Index of the last word slot inside the rate, per mode.
  localparam logic [CW-1:0] LAST_R1088 = CW'(1088 / IN_W - 1);
  localparam logic [CW-1:0] LAST_R576  = CW'(576 / IN_W - 1);
  localparam logic [CW-1:0] LAST_R1344 = CW'(1344 / IN_W - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_FULL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q;
  logic            last_q, last_d;
  logic            out_ready_q;
  logic            buffer_full_q;
  logic [IN_W-1:0] buf_q [MAX_WORDS];
  logic [IN_W-1:0] buf_d [MAX_WORDS];

  logic [CW-1:0]   last_slot_s;
  logic [7:0]      suffix_s;
  logic            final_slot_s;

  // Builds the message word that carries the suffix: valid bytes kept,
  // suffix right after them, zeros beyond, and the pad10*1 closing bit
  // when the word lands in the last slot of the rate.
  function automatic logic [IN_W-1:0] pad_word(
    input logic [IN_W-1:0] data,
    input logic [BW-1:0]   nbytes,
    input logic [7:0]      sfx,
    input logic            final_slot
  );
    logic [IN_W-1:0] w;
    logic [7:0]      b_val;
    w = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < int'(nbytes)) begin
        b_val = 8'(data >> (8 * (NB - 1 - b)));
      end else if (b == int'(nbytes)) begin
        b_val = sfx;
      end else begin
        b_val = 8'h00;
      end
      w = w | (IN_W'(b_val) << (8 * (NB - 1 - b)));
    end
    if (final_slot) begin
      w = w | IN_W'(8'h80);
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Rate (as last slot index) and suffix byte for the captured mode.
  always_comb begin
    last_slot_s = LAST_R1088;
    suffix_s    = 8'h06;
    case (mode_q)
      2'd0: begin
        last_slot_s = LAST_R1088;
        suffix_s    = 8'h06;
      end
      2'd1: begin
        last_slot_s = LAST_R576;
        suffix_s    = 8'h06;
      end
      2'd2: begin
        last_slot_s = LAST_R1344;
        suffix_s    = 8'h1F;
      end
      2'd3: begin
        last_slot_s = LAST_R1088;
        suffix_s    = 8'h1F;
      end
      default: begin
        last_slot_s = LAST_R1088;
        suffix_s    = 8'h06;
      end
    endcase
  end

  assign final_slot_s = (cnt_q == last_slot_s);

  // Next-state, slot counter and buffer update for the fill/pad/handoff cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    buf_d   = buf_q;
    case (state_q)
      S_FILL: begin
        if (in_ready_i) begin
          if (is_last_i) begin
            buf_d[cnt_q] = pad_word(in_i, byte_num_i, suffix_s, final_slot_s);
            last_d       = 1'b1;
          end else begin
            buf_d[cnt_q] = in_i;
          end
          cnt_d = cnt_q + CW'(1);
          if (final_slot_s) begin
            state_d = S_FULL;
          end else if (is_last_i) begin
            state_d = S_PAD;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_PAD: begin
        // Zero fill; the closing 0x80 goes into the last byte of the rate.
        if (final_slot_s) begin
          buf_d[cnt_q] = IN_W'(8'h80);
          state_d      = S_FULL;
        end else begin
          buf_d[cnt_q] = '0;
          state_d      = S_PAD;
        end
        cnt_d = cnt_q + CW'(1);
      end
      S_FULL: begin
        if (f_ack_i) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            buf_d   = '{default: '0};
            cnt_d   = '0;
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FULL;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
        last_d  = 1'b0;
        buf_d   = '{default: '0};
      end
    endcase
  end

  // Control registers; reset also captures the hash mode.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_FILL;
      cnt_q         <= '0;
      mode_q        <= mode_i;
      last_q        <= 1'b0;
      out_ready_q   <= 1'b0;
      buffer_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_q;
      last_q        <= last_d;
      out_ready_q   <= (state_d == S_FULL);
      buffer_full_q <= (state_d == S_PAD) || (state_d == S_FULL);
    end
  end

  // Block buffer storage, one IN_W-bit word per slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Slot 0 sits at the top of the block; unused slots stay zero.
  for (genvar g = 0; g < MAX_WORDS; g++) begin : g_pack
    assign out_o[OUT_W-1-g*IN_W -: IN_W] = buf_q[g];
  end

  assign out_ready_o   = out_ready_q;
  assign buffer_full_o = buffer_full_q;
  assign out_last_o    = last_q;

endmodule

// File: tb/tb_keccak_padder_multi.sv
// Bench for keccak_padder_multi: three instances (IN_W 32, 64, 8), one active
// at a time, checked each cycle against a byte-level block model plus
// hand-computed literal expectations.
module tb_keccak_padder_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v, rdy_v, last_v, ack_v;
  logic [1:0]  mode_v;
  logic [63:0] in_v;
  logic [2:0]  bn_v;
  int          sel;

  logic          bf0, bf1, bf2, rd0, rd1, rd2, ol0, ol1, ol2;
  logic [1343:0] out0, out1, out2;
  logic          o_bf, o_rdy, o_last;
  logic [1343:0] o_out;

  keccak_padder_multi #(.IN_W(32)) u_dut32 (
    .clk_i(clk), .reset_i(rst_v), .mode_i(mode_v), .in_i(in_v[31:0]),
    .in_ready_i(rdy_v && (sel == 0)), .is_last_i(last_v), .byte_num_i(bn_v[1:0]),
    .f_ack_i(ack_v && (sel == 0)), .buffer_full_o(bf0), .out_o(out0),
    .out_ready_o(rd0), .out_last_o(ol0));

  keccak_padder_multi #(.IN_W(64)) u_dut64 (
    .clk_i(clk), .reset_i(rst_v), .mode_i(mode_v), .in_i(in_v),
    .in_ready_i(rdy_v && (sel == 1)), .is_last_i(last_v), .byte_num_i(bn_v),
    .f_ack_i(ack_v && (sel == 1)), .buffer_full_o(bf1), .out_o(out1),
    .out_ready_o(rd1), .out_last_o(ol1));

  keccak_padder_multi #(.IN_W(8)) u_dut8 (
    .clk_i(clk), .reset_i(rst_v), .mode_i(mode_v), .in_i(in_v[7:0]),
    .in_ready_i(rdy_v && (sel == 2)), .is_last_i(last_v), .byte_num_i(bn_v[0:0]),
    .f_ack_i(ack_v && (sel == 2)), .buffer_full_o(bf2), .out_o(out2),
    .out_ready_o(rd2), .out_last_o(ol2));

  always_comb begin
    case (sel)
      1: begin o_bf = bf1; o_rdy = rd1; o_last = ol1; o_out = out1; end
      2: begin o_bf = bf2; o_rdy = rd2; o_last = ol2; o_out = out2; end
      default: begin o_bf = bf0; o_rdy = rd0; o_last = ol0; o_out = out0; end
    endcase
  end

  // ---------------- model: message bytes of the current block ----------------
  localparam int P_FILL = 0, P_PAD = 1, P_FULL = 2, P_DONE = 3;
  int         ph, n, rb, nb;
  logic       lastm;
  logic [1:0] mode_m;
  logic [7:0] blk [168];

  int n_pass = 0;
  int n_chk  = 0;

  function automatic int rate_bytes(input logic [1:0] m);
    case (m)
      2'd1: return 72;
      2'd2: return 168;
      default: return 136;
    endcase
  endfunction

  function automatic int word_bytes(input int s);
    case (s)
      1: return 8;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] d;
    if (rst_v) begin
      mode_m = mode_v;
      rb     = rate_bytes(mode_v);
      nb     = word_bytes(sel);
      ph     = P_FILL;
      n      = 0;
      lastm  = 1'b0;
      for (int i = 0; i < 168; i++) blk[i] = 8'h00;
    end else begin
      case (ph)
        P_FILL: if (rdy_v) begin
          for (int b = 0; b < nb; b++) begin
            d = 8'(in_v >> (8 * (nb - 1 - b)));
            if (!last_v || b < int'(bn_v)) blk[n+b] = d;
            else if (b == int'(bn_v)) blk[n+b] = mode_m[1] ? 8'h1F : 8'h06;
            else blk[n+b] = 8'h00;
          end
          if (last_v) lastm = 1'b1;
          n = n + nb;
          if (n == rb) ph = P_FULL;
          else if (last_v) ph = P_PAD;
        end
        P_PAD: begin
          n = n + nb;
          if (n == rb) ph = P_FULL;
        end
        P_FULL: if (ack_v) begin
          if (lastm) ph = P_DONE;
          else begin
            for (int i = 0; i < 168; i++) blk[i] = 8'h00;
            n  = 0;
            ph = P_FILL;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Padded block = message bytes, then pad10*1's closing bit on the last rate byte.
  function automatic logic [1343:0] exp_block();
    logic [1343:0] e;
    e = '0;
    for (int i = 0; i < 168; i++) e = e | (1344'(blk[i]) << (1336 - 8 * i));
    if (lastm && ph == P_FULL) e = e | (1344'(8'h80) << (1336 - 8 * (rb - 1)));
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_out(input string nm, input logic [1343:0] act, input logic [1343:0] exp);
    int first;
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      first = -1;
      for (int i = 167; i >= 0; i--) if (act[8*i +: 8] !== exp[8*i +: 8]) first = 167 - i;
      $display("FAIL %s: block byte %0d got %h expected %h (t=%0t)", nm, first,
               act[8*(167-first) +: 8], exp[8*(167-first) +: 8], $time);
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("out_ready", 64'(o_rdy), 64'(ph == P_FULL));
    chk("buffer_full", 64'(o_bf), 64'(ph == P_PAD || ph == P_FULL));
    if (ph == P_FULL) chk("out_last", 64'(o_last), 64'(lastm));
    if (ph == P_FULL || rst_v) chk_out("out", o_out, exp_block());
  endtask

  task automatic do_reset(input int s, input logic [1:0] m);
    sel = s; mode_v = m; rst_v = 1'b1; rdy_v = 1'b0; ack_v = 1'b0; last_v = 1'b0;
    bn_v = 3'd0; in_v = 64'd0;
    tick(); tick();
    chk("rst_out_ready", 64'(o_rdy), 64'd0);
    chk("rst_buffer_full", 64'(o_bf), 64'd0);
    chk("rst_out_zero", 64'(o_out == '0), 64'd1);
    rst_v = 1'b0;
    mode_v = m ^ 2'd1;  // must have no effect until the next reset
  endtask

  // Empty SHA3-512 message on the 32-bit instance.
  task automatic run_empty(input string tag);
    int k;
    repeat (7) tick();
    in_v = 64'h12345678; rdy_v = 1'b1; last_v = 1'b1; bn_v = 3'd0;
    tick();
    in_v = 64'hDEADBEEF;  // second is_last word, held by the source
    k = 0;
    while (o_rdy !== 1'b1 && k < 40) begin tick(); k++; end
    chk({tag, "_latency"}, 64'(k), 64'd17);
    chk({tag, "_word0"}, 64'(o_out[1343 -: 32]), 64'h06000000);
    chk({tag, "_mid_zero"}, 64'(o_out[1311:800] == '0), 64'd1);
    chk({tag, "_word17"}, 64'(o_out[799 -: 32]), 64'h00000080);
    chk({tag, "_below_rate"}, 64'(o_out[767:0] == '0), 64'd1);
    chk({tag, "_last"}, 64'(o_last), 64'd1);
    ack_v = 1'b1;
    tick();
    ack_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({tag, "_done_ready"}, 64'(o_rdy), 64'd0);
      chk({tag, "_done_full"}, 64'(o_bf), 64'd0);
    end
    rdy_v = 1'b0; last_v = 1'b0;
  endtask

  logic [7:0] fin_exp [2];
  logic [1:0] m4 [2];
  int k6;

  initial begin
    sel = 0; rst_v = 1'b1; rdy_v = 1'b0; last_v = 1'b0; ack_v = 1'b0;
    mode_v = 2'd1; in_v = 64'd0; bn_v = 3'd0;

    // Scenario 1: empty message, SHA3-512, 32-bit words.
    do_reset(0, 2'd1);
    run_empty("s1");

    // Scenario 5: reset in the middle of PAD, then a fresh empty message.
    do_reset(0, 2'd1);
    in_v = 64'h0; rdy_v = 1'b1; last_v = 1'b1; bn_v = 3'd0;
    tick();
    rdy_v = 1'b0; last_v = 1'b0;
    repeat (5) tick();
    chk("s5_in_pad", 64'(o_bf), 64'd1);
    mode_v = 2'd1; rst_v = 1'b1;
    tick();
    chk("s5_rst_ready", 64'(o_rdy), 64'd0);
    chk("s5_rst_full", 64'(o_bf), 64'd0);
    chk("s5_rst_last", 64'(o_last), 64'd0);
    chk("s5_rst_out", 64'(o_out == '0), 64'd1);
    rst_v = 1'b0; mode_v = 2'd3;
    run_empty("s5");

    // Scenario 2: 17 full words then a 3-byte final word in the last slot.
    do_reset(0, 2'd1);
    for (int i = 0; i < 17; i++) begin
      in_v = (i % 2 == 0) ? 64'hEFCDAB90 : 64'h78563412;
      rdy_v = 1'b1; last_v = 1'b0;
      tick();
    end
    in_v = 64'h78563412; last_v = 1'b1; bn_v = 3'd3;
    tick();
    rdy_v = 1'b0; last_v = 1'b0;
    chk("s2_ready", 64'(o_rdy), 64'd1);
    chk("s2_word0", 64'(o_out[1343 -: 32]), 64'hEFCDAB90);
    chk("s2_final_word", 64'(o_out[799 -: 32]), 64'h78563486);
    chk("s2_last", 64'(o_last), 64'd1);
    ack_v = 1'b1; tick(); ack_v = 1'b0;
    tick();

    // Scenario 3: SHAKE128 full block, held word, then resume after ack.
    do_reset(0, 2'd2);
    for (int i = 0; i < 42; i++) begin
      in_v = 64'(32'hA5000000 + 32'(i)); rdy_v = 1'b1; last_v = 1'b0;
      tick();
    end
    chk("s3_ready", 64'(o_rdy), 64'd1);
    chk("s3_last", 64'(o_last), 64'd0);
    chk("s3_full", 64'(o_bf), 64'd1);
    chk("s3_slot41", 64'(o_out[31:0]), 64'hA5000029);
    in_v = 64'hCAFEF00D;
    repeat (3) tick();
    chk("s3_held_ready", 64'(o_rdy), 64'd1);
    ack_v = 1'b1; tick(); ack_v = 1'b0;
    chk("s3_ack_ready", 64'(o_rdy), 64'd0);
    chk("s3_ack_full", 64'(o_bf), 64'd0);
    tick();
    rdy_v = 1'b0;
    chk("s3_slot0", 64'(o_out[1343 -: 32]), 64'hCAFEF00D);
    chk("s3_rest_zero", 64'(o_out[1311:0] == '0), 64'd1);
    tick();

    // Scenario 4: 64-bit words, SHA3-256 vs SHAKE256, suffix in the last byte.
    fin_exp[0] = 8'h86; fin_exp[1] = 8'h9F;
    m4[0] = 2'd0; m4[1] = 2'd3;
    for (int t = 0; t < 2; t++) begin
      do_reset(1, m4[t]);
      for (int i = 0; i < 16; i++) begin
        in_v = 64'h0011223344556677 + 64'(i); rdy_v = 1'b1; last_v = 1'b0;
        tick();
      end
      in_v = 64'h8899AABBCCDDEEFF; last_v = 1'b1; bn_v = 3'd7;
      tick();
      rdy_v = 1'b0; last_v = 1'b0; bn_v = 3'd0;
      chk("s4_ready", 64'(o_rdy), 64'd1);
      chk("s4_final_byte", 64'(o_out[263:256]), 64'(fin_exp[t]));
      chk("s4_byte6", 64'(o_out[271:264]), 64'hEE);
      chk("s4_capacity_zero", 64'(o_out[255:0] == '0), 64'd1);
      ack_v = 1'b1; tick(); ack_v = 1'b0;
      tick();
    end

    // Scenario 6: "abc" on 8-bit words, SHA3-512.
    do_reset(2, 2'd1);
    in_v = 64'h61; rdy_v = 1'b1; last_v = 1'b0; tick();
    in_v = 64'h62; tick();
    in_v = 64'h63; tick();
    in_v = 64'hFF; last_v = 1'b1; bn_v = 3'd0; tick();
    rdy_v = 1'b0; last_v = 1'b0;
    k6 = 0;
    while (o_rdy !== 1'b1 && k6 < 100) begin tick(); k6++; end
    chk("s6_latency", 64'(k6), 64'd68);
    chk("s6_top", 64'(o_out[1343 -: 32]), 64'h61626306);
    chk("s6_final_byte", 64'(o_out[775:768]), 64'h80);
    chk("s6_capacity_zero", 64'(o_out[767:0] == '0), 64'd1);
    chk("s6_last", 64'(o_last), 64'd1);
    ack_v = 1'b1; tick(); ack_v = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
